// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA read-response engine.
// Holds the FSM state type, the per-beat FIFO payload, the byte-mask helpers
// and the 4 KiB boundary constant.
package dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_DATA = 2'd2
   } dma_state_e;

   // One response beat as it travels through the response FIFO.
   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  be;
      logic        last;
   } dma_beat_t;

   localparam logic [3:0] BE_ALL = 4'hF;

   // Address bit where a 4 KiB page starts; requests may not cross it when
   // the bound check is built in.
   localparam int unsigned BOUND_LSB = 12;

   // Bytes at or above the start offset are valid in the first beat.
   function automatic logic [3:0] be_first(input logic [1:0] off);
      return BE_ALL << off;
   endfunction

   // Bytes at or below the end offset are valid in the last beat.
   function automatic logic [3:0] be_last(input logic [1:0] off);
      return BE_ALL >> (2'd3 - off);
   endfunction

endpackage

// File: rtl/dma_rd_resp_if.sv
// dma_rd_resp_if: request and response-data channels of the DMA read engine.
// The err signal only exists when DMA_RD_RESP_BOUND_CHK_EN is defined.
interface dma_rd_resp_if;

   logic        req;
   logic [31:0] addr;
   logic [15:0] len;
   logic        ack;
   logic        dvld;
   logic        d_last;
   logic [31:0] data;
   logic [3:0]  be;
   logic        dack;
`ifdef DMA_RD_RESP_BOUND_CHK_EN
   logic        err;

   modport master (output req, addr, len, dack,
                   input  ack, err, dvld, d_last, data, be);
   modport slave  (input  req, addr, len, dack,
                   output ack, err, dvld, d_last, data, be);
`else
   modport master (output req, addr, len, dack,
                   input  ack, dvld, d_last, data, be);
   modport slave  (input  req, addr, len, dack,
                   output ack, dvld, d_last, data, be);
`endif

endinterface

// File: rtl/dma_rsp_fifo.sv
// dma_rsp_fifo: 2-entry response FIFO (data + byte mask + last flag).
// The head entry is presented combinationally; the writer guarantees it
// never pushes into a full FIFO.
module dma_rsp_fifo
   import dma_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  dma_beat_t  wr_beat,
   input  logic       rd_en,
   output dma_beat_t  rd_beat,
   output logic       not_empty,
   output logic [1:0] count
);

   dma_beat_t  slot [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] cnt;
   logic       do_rd;

   assign do_rd     = rd_en && (cnt != 2'd0);
   assign not_empty = (cnt != 2'd0);
   assign count     = cnt;
   assign rd_beat   = slot[rd_ptr];

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the two slots are reset because they drive data/be directly,
         // which must read zero during reset; a deeper RAM would not be reset.
         slot[0] <= '0;
         slot[1] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         cnt     <= 2'd0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, so slot write and pointer update cannot race.
         if (wr_en) begin
            slot[wr_ptr] <= wr_beat;
            wr_ptr       <= ~wr_ptr;
         end
         if (do_rd) begin
            rd_ptr <= ~rd_ptr;
         end
         cnt <= cnt + {1'b0, wr_en} - {1'b0, do_rd};
      end
   end

endmodule

// File: rtl/dma_rd_resp.sv
// dma_rd_resp: DMA read-response engine. Accepts a byte-addressed read
// request, reads the backing memory word by word and returns beats with
// byte-valid masks through a 2-entry FIFO under dvld/dack flow control.
// Build option: DMA_RD_RESP_BOUND_CHK_EN adds bus.err and rejects requests
// that cross a 4 KiB boundary.
module dma_rd_resp
   import dma_pkg::*;
#(
   parameter int MEM_AW = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   dma_rd_resp_if.slave      bus,
   output logic              mem_rd,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [31:0]       mem_rdata
);

   dma_state_e  state;
   logic [16:0] rd_left;
   logic        first_rd;
   logic [1:0]  first_off;
   logic [1:0]  last_off;
   logic [1:0]  end_off;
   logic [16:0] beats_in;
   logic        bound_err;
   logic        pend;
   logic [3:0]  pend_be;
   logic        pend_last;
   logic [3:0]  issue_be;
   logic        issue_last;
   dma_beat_t   wr_beat;
   dma_beat_t   head;
   logic        fifo_ne;
   logic [1:0]  fifo_cnt;
   logic        pop;
   logic [2:0]  credit_used;

   // Request decode: end-byte offset and beat count from the live inputs.
   assign end_off  = bus.addr[1:0] + bus.len[1:0] - 2'd1;
   assign beats_in = ({15'd0, bus.addr[1:0]} + {1'b0, bus.len} + 17'd3) >> 2;

`ifdef DMA_RD_RESP_BOUND_CHK_EN
   logic [31:0] end_addr;

   assign end_addr  = bus.addr + {16'd0, bus.len} - 32'd1;
   assign bound_err = |((bus.addr ^ end_addr) >> BOUND_LSB);

   // err accompanies the ack pulse of a rejected request and is 0 otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.err <= 1'b0;
      end else begin
         bus.err <= (state == ST_IDLE) && bus.req && bound_err;
      end
   end
`else
   assign bound_err = 1'b0;
`endif

   // A beat leaves when the FIFO has one and the requester takes it.
   assign pop = fifo_ne && bus.dack;

   // Slots committed after this edge: FIFO entries left after the pop plus
   // the read whose data is returning now. mem_rd is combinational so the
   // pop of this cycle frees a slot immediately; that is what sustains one
   // beat per cycle with only two slots.
   assign credit_used = {1'b0, fifo_cnt} + {2'b00, pend} - {2'b00, pop};
   assign mem_rd      = (state != ST_IDLE) && (rd_left != 17'd0) &&
                        (credit_used < 3'd2);

   // Byte mask and last flag of the read being issued this cycle.
   assign issue_last = (rd_left == 17'd1);
   assign issue_be   = (first_rd   ? be_first(first_off) : BE_ALL) &
                       (issue_last ? be_last(last_off)   : BE_ALL);

   // Request FSM with registered ack and read-address bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bus.ack   <= 1'b0;
         rd_left   <= 17'd0;
         first_rd  <= 1'b0;
         first_off <= 2'd0;
         last_off  <= 2'd0;
         mem_addr  <= '0;
      end else begin
         bus.ack <= 1'b0;
         if (mem_rd) begin
            rd_left  <= rd_left - 17'd1;
            first_rd <= 1'b0;
            mem_addr <= mem_addr + MEM_AW'(1);
         end
         case (state)
            ST_IDLE: begin
               if (bus.req) begin
                  state     <= ST_ACK;
                  bus.ack   <= 1'b1;
                  rd_left   <= (bound_err || bus.len == 16'd0) ? 17'd0 : beats_in;
                  first_rd  <= 1'b1;
                  first_off <= bus.addr[1:0];
                  last_off  <= end_off;
                  mem_addr  <= bus.addr[MEM_AW+1:2];
               end
            end
            ST_ACK: begin
               state <= (rd_left == 17'd0) ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
               if (pop && head.last) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Mask/last of the read in flight, paired with mem_rdata one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend      <= 1'b0;
         pend_be   <= 4'd0;
         pend_last <= 1'b0;
      end else begin
         pend <= mem_rd;
         if (mem_rd) begin
            pend_be   <= issue_be;
            pend_last <= issue_last;
         end
      end
   end

   assign wr_beat = '{data: mem_rdata, be: pend_be, last: pend_last};

   dma_rsp_fifo u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (pend),
      .wr_beat   (wr_beat),
      .rd_en     (pop),
      .rd_beat   (head),
      .not_empty (fifo_ne),
      .count     (fifo_cnt)
   );

   assign bus.dvld   = fifo_ne;
   assign bus.data   = head.data;
   assign bus.be     = head.be;
   assign bus.d_last = fifo_ne && head.last;

endmodule

// File: tb/tb_dma_rd_resp.sv
// tb_dma_rd_resp: scoreboard bench for dma_rd_resp. Expected beats and memory
// addresses are queued when a request is driven and compared as the DUT
// issues reads and delivers beats.
module tb_dma_rd_resp;

   localparam int TB_AW = 14;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  be;
      logic        last;
      int          n;
   } exp_beat_t;

   logic             clk;
   logic             rst_n;
   logic             mem_rd;
   logic [TB_AW-1:0] mem_addr;
   logic [31:0]      mem_rdata;

   dma_rd_resp_if bus_if ();

   dma_rd_resp #(.MEM_AW(TB_AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_if),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata)
   );

   exp_beat_t        sbq [$];
   logic [TB_AW-1:0] mq  [$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_ack    = 0;
   int n_rd     = 0;
   int beats_done = 0;
   int ack_cyc  = 0;
   int first_cyc = 0;
   int dack_mode = 0;
   int phase    = 0;
   bit first_pend = 0;
   bit stalled  = 0;
   logic [31:0] held_data;
   logic [3:0]  held_be;
   logic        held_last;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] mem_word(input logic [TB_AW-1:0] w);
      return {2'b10, w, 2'b01, ~w};
   endfunction

   // Backing memory: data one cycle after the strobe, garbage otherwise.
   always @(posedge clk) begin
      mem_rdata <= mem_rd ? mem_word(mem_addr) : 32'hDEAD_BEEF;
   end

   // Requester data-accept pattern.
   initial begin
      bus_if.dack = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (dack_mode)
            0: bus_if.dack = 1'b1;
            1: begin
               bus_if.dack = (phase == 0);
               phase = (phase + 1) % 3;
            end
            default: bus_if.dack = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      exp_beat_t e;
      logic [TB_AW-1:0] ea;
      cyc++;
      if (rst_n) begin
         if (bus_if.ack) begin
            n_ack++;
            ack_cyc    = cyc;
            first_pend = 1'b1;
         end
         if (mem_rd) begin
            n_rd++;
            if (mq.size() == 0) check("mem_rd_extra", 1, 0);
            else begin
               ea = mq.pop_front();
               check("mem_addr", mem_addr, ea);
            end
         end
         if (stalled) begin
            check("hold_dvld", bus_if.dvld, 1);
            check("hold_data", {bus_if.data, bus_if.be, bus_if.d_last},
                  {held_data, held_be, held_last});
         end
         if (bus_if.dvld) begin
            if (first_pend) begin
               check("ack_to_dvld", cyc - ack_cyc, 2);
               first_pend = 1'b0;
               first_cyc  = cyc;
            end
            if (bus_if.dack) begin
               beats_done++;
               if (sbq.size() == 0) check("beat_extra", 1, 0);
               else begin
                  e = sbq.pop_front();
                  check("data", bus_if.data, e.data);
                  check("be", bus_if.be, e.be);
                  check("d_last", bus_if.d_last, e.last);
                  if (e.last && dack_mode == 0) check("burst_cycles", cyc - first_cyc, e.n - 1);
               end
            end
            stalled   = !bus_if.dack;
            held_data = bus_if.data;
            held_be   = bus_if.be;
            held_last = bus_if.d_last;
         end else begin
            stalled = 1'b0;
         end
         if (mem_rd) check("outstanding_le2", (n_rd - beats_done) <= 2, 1);
      end
   end

   // Reference model: expected beats and word addresses of one request.
   task automatic push_expect(input logic [31:0] a, input logic [15:0] l, output logic berr);
      logic [31:0] e_addr;
      logic [29:0] w;
      int n;
      e_addr = a + {16'd0, l} - 32'd1;
      berr = 1'b0;
`ifdef DMA_RD_RESP_BOUND_CHK_EN
      berr = (a[31:12] != e_addr[31:12]);
`endif
      n = (l == 16'd0 || berr) ? 0 : (int'(a[1:0]) + int'(l) + 3) / 4;
      for (int i = 0; i < n; i++) begin
         exp_beat_t b;
         w = a[31:2] + 30'(i);
         for (int k = 0; k < 4; k++) begin
            b.be[k] = 1'b1;
            if (i == 0 && k < int'(a[1:0])) b.be[k] = 1'b0;
            if (i == n - 1 && k > int'(e_addr[1:0])) b.be[k] = 1'b0;
         end
         b.data = mem_word(w[TB_AW-1:0]);
         b.last = (i == n - 1);
         b.n    = n;
         sbq.push_back(b);
         mq.push_back(w[TB_AW-1:0]);
      end
   endtask

   task automatic start_req(input logic [31:0] a, input logic [15:0] l);
      logic exp_err;
      bit got;
      push_expect(a, l, exp_err);
      @(posedge clk);
      #1;
      bus_if.req  = 1'b1;
      bus_if.addr = a;
      bus_if.len  = l;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         #1;
         got = bus_if.ack;
      end
      check("ack_seen", got, 1);
`ifdef DMA_RD_RESP_BOUND_CHK_EN
      if (got) check("err", bus_if.err, exp_err);
`endif
      @(posedge clk);
      #1;
      bus_if.req  = 1'b0;
      bus_if.addr = $urandom;
      bus_if.len  = 16'($urandom);
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 1000 && !done; k++) begin
         @(negedge clk);
         #1;
         done = (sbq.size() == 0) && (mq.size() == 0) && !bus_if.dvld;
      end
      check("drain", done, 1);
      if (!done) begin
         sbq.delete();
         mq.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run_req(input logic [31:0] a, input logic [15:0] l);
      int a0;
      a0 = n_ack;
      start_req(a, l);
      wait_drain();
      check("ack_once", n_ack - a0, 1);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ack"}, bus_if.ack, 0);
      check({tag, "_dvld"}, bus_if.dvld, 0);
      check({tag, "_d_last"}, bus_if.d_last, 0);
      check({tag, "_mem_rd"}, mem_rd, 0);
      check({tag, "_data"}, bus_if.data, 0);
      check({tag, "_be"}, bus_if.be, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
   endtask

   task automatic reset_mid();
      int b0;
      bit seen;
      dack_mode = 0;
      b0 = beats_done;
      start_req(32'h0000_0200, 16'd16);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         #1;
         seen = (beats_done > b0);
      end
      check("mid_beat1", seen, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_quiet("mid_rst");
      sbq.delete();
      mq.delete();
      n_rd       = 0;
      beats_done = 0;
      stalled    = 1'b0;
      first_pend = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check("post_rst_dvld", bus_if.dvld, 0);
   endtask

   initial begin
      rst_n       = 1'b0;
      bus_if.req  = 1'b0;
      bus_if.addr = 32'd0;
      bus_if.len  = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      check_quiet("rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      dack_mode = 0;
      run_req(32'h0000_0100, 16'd16);
      run_req(32'h0000_0101, 16'd6);
      run_req(32'h0000_0102, 16'd1);
      dack_mode = 1;
      run_req(32'h0000_0000, 16'd12);
      dack_mode = 0;
      run_req(32'h0000_0040, 16'd0);
      run_req(32'h0000_0041, 16'd0);
      run_req(32'hFFFF_FFFC, 16'd8);
      run_req(32'h0000_0FFC, 16'd8);
      run_req(32'h0000_0FF8, 16'd8);
      dack_mode = 1;
      run_req(32'h0000_0003, 16'd9);
      dack_mode = 2;
      for (int i = 0; i < 8; i++) begin
         run_req($urandom, 16'($urandom_range(1, 40)));
      end
      reset_mid();
      dack_mode = 0;
      run_req(32'h0000_0300, 16'd16);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
